// File: rtl/eq_search_ctrl.sv
// Linear-search lookup controller: one shared 16-bit equality comparator walks a
// small tag table one entry per cycle and reports hit/miss plus the lowest matching index.

module is_equal #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic         eq_o
);
    assign eq_o = &(~(x_i ^ y_i));
endmodule

module eq_search_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_ready,
    input  logic              clr,
    input  logic              srch_valid,
    input  logic [15:0]       srch_key,
    output logic              srch_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [ADDR_W-1:0] res_idx,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(0);

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [15:0]         key_q;
    logic [DEPTH-1:0]    valid_q;
    logic [15:0]         entry_q [DEPTH];
    logic                res_hit_q;
    logic [ADDR_W-1:0]   res_idx_q;
    logic                res_valid_q;
    logic                busy_q;
    logic                srch_ready_q;
    logic                wr_ready_q;

    logic                eq_s;
    logic                match_s;
    logic                wr_fire_s;

    // The single comparator always looks at the latched key and the entry under the pointer.
    is_equal #(.W(16)) u_eq (
        .x_i  (key_q),
        .y_i  (entry_q[ptr_q]),
        .eq_o (eq_s)
    );

    assign match_s   = eq_s & valid_q[ptr_q];
    assign ptr_d     = ptr_q + ONE_IDX;
    // clr wins over a simultaneous write, and writes are only honoured in IDLE.
    assign wr_fire_s = wr_en & wr_ready_q & ~clr;

    // Table data storage; contents need no reset because the valid vector gates every match.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            entry_q[wr_addr] <= wr_data;
        end
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= ZERO_IDX;
            key_q        <= 16'h0000;
            valid_q      <= '0;
            res_hit_q    <= 1'b0;
            res_idx_q    <= ZERO_IDX;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            srch_ready_q <= 1'b1;
            wr_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr) begin
                        valid_q <= '0;
                    end else if (wr_fire_s) begin
                        valid_q[wr_addr] <= 1'b1;
                    end
                    if (srch_valid && srch_ready_q) begin
                        key_q        <= srch_key;
                        ptr_q        <= ZERO_IDX;
                        state_q      <= S_SEARCH;
                        busy_q       <= 1'b1;
                        srch_ready_q <= 1'b0;
                        wr_ready_q   <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (match_s) begin
                        state_q     <= S_DONE;
                        res_hit_q   <= 1'b1;
                        res_idx_q   <= ptr_q;
                        res_valid_q <= 1'b1;
                    end else if (ptr_q == LAST_IDX) begin
                        state_q     <= S_DONE;
                        res_hit_q   <= 1'b0;
                        res_idx_q   <= ZERO_IDX;
                        res_valid_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_d;
                    end
                end
                S_DONE: begin
                    // res_hit/res_idx stay put after the handshake until the next result.
                    if (res_ready) begin
                        state_q      <= S_IDLE;
                        res_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        srch_ready_q <= 1'b1;
                        wr_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    res_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    srch_ready_q <= 1'b1;
                    wr_ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready   = wr_ready_q;
    assign srch_ready = srch_ready_q;
    assign res_valid  = res_valid_q;
    assign res_hit    = res_hit_q;
    assign res_idx    = res_idx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_eq_search_ctrl.sv
// Directed plus randomized bench for eq_search_ctrl against a table/array reference model.

module tb_eq_search_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clr;
    logic        srch_valid;
    logic [15:0] srch_key;
    logic        srch_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [2:0]  res_idx;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] m_data  [8];
    bit          m_valid [8];

    always #5 clk = ~clk;

    eq_search_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr        (clr),
        .srch_valid (srch_valid),
        .srch_key   (srch_key),
        .srch_ready (srch_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_hit    (res_hit),
        .res_idx    (res_idx),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        m_data[a]  = d;
        m_valid[a] = 1'b1;
    endtask

    // Full search transaction: optional same-edge write, optional ignored write/clr poke
    // during SEARCH, optional stall of res_ready while the result is presented.
    task automatic srch(input string tag, input logic [15:0] key, input int hold,
                        input bit poke, input bit wr_same,
                        input logic [2:0] waddr, input logic [15:0] wdata);
        bit       exp_hit;
        int       exp_idx;
        int       exp_lat;
        int       cyc;
        if (wr_same) begin
            wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
            m_data[waddr]  = wdata;
            m_valid[waddr] = 1'b1;
        end
        exp_hit = 1'b0;
        exp_idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (!exp_hit && m_valid[i] && m_data[i] == key) begin
                exp_hit = 1'b1;
                exp_idx = i;
            end
        end
        exp_lat = exp_hit ? exp_idx + 1 : 8;

        srch_valid = 1'b1; srch_key = key;
        step();
        srch_valid = 1'b0; wr_en = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_srdy0"}, 32'(srch_ready), 32'd0);
        if (poke) begin
            wr_en = 1'b1; clr = 1'b1; wr_addr = 3'd0; wr_data = 16'h7777;
            chk({tag, "_wrdy0"}, 32'(wr_ready), 32'd0);
        end
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 40) begin
            step();
            wr_en = 1'b0; clr = 1'b0;
            cyc++;
        end
        wr_en = 1'b0; clr = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(res_hit), 32'(exp_hit));
        chk({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_v"}, 32'(res_valid), 32'd1);
            chk({tag, "_hold_hit"}, 32'(res_hit), 32'(exp_hit));
            chk({tag, "_hold_idx"}, 32'(res_idx), 32'(exp_idx));
            chk({tag, "_hold_srdy"}, 32'(srch_ready), 32'd0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_post_v"}, 32'(res_valid), 32'd0);
        chk({tag, "_post_srdy"}, 32'(srch_ready), 32'd1);
        chk({tag, "_post_busy"}, 32'(busy), 32'd0);
        chk({tag, "_post_idx"}, 32'(res_idx), 32'(exp_idx));
    endtask

    initial begin
        logic [15:0] rk;
        logic [15:0] rd;
        logic [2:0]  ra;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; clr = 1'b0;
        srch_valid = 1'b0; srch_key = 16'h0000; res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_data[i] = 16'h0000;
            m_valid[i] = 1'b0;
        end
        step();
        step();
        chk("rst_rv", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_srdy", 32'(srch_ready), 32'd1);
        chk("rst_wrdy", 32'(wr_ready), 32'd1);
        chk("rst_hit", 32'(res_hit), 32'd0);
        chk("rst_idx", 32'(res_idx), 32'd0);
        rst_n = 1'b1;
        step();

        srch("empty0", 16'h0000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
        srch("k1005", 16'h1005, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        wr(3'd2, 16'hBEEF);
        wr(3'd6, 16'hBEEF);
        srch("dup", 16'hBEEF, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        srch("miss_hold", 16'hFFFF, 5, 1'b0, 1'b0, 3'd0, 16'h0000);

        srch("same_edge", 16'h00A5, 0, 1'b1, 1'b1, 3'd4, 16'h00A5);
        srch("poke_ign", 16'h7777, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        srch("poke_keep", 16'h1000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        step();
        clr = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        srch("clr_miss", 16'h1003, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        srch("clr_wr_ign", 16'h1234, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        wr(3'd0, 16'h8001);
        srch("msb_miss", 16'h0001, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        srch("msb_hit", 16'h8001, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < 2; w++) begin
                ra = 3'($urandom_range(0, 7));
                rd = 16'h4000 | 16'($urandom_range(0, 7));
                wr(ra, rd);
            end
            rk = 16'h4000 | 16'($urandom_range(0, 7));
            srch("rand", rk, int'($urandom_range(0, 2)), 1'b0, 1'b0, 3'd0, 16'h0000);
        end

        // Asynchronous reset in the middle of a scan.
        srch_valid = 1'b1; srch_key = 16'h5555;
        step();
        srch_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rv", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_srdy", 32'(srch_ready), 32'd1);
        chk("mid_rst_wrdy", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        rst_n = 1'b1;
        step();
        chk("mid_rst_rv2", 32'(res_valid), 32'd0);
        srch("post_rst0", 16'h0000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
